// File: rtl/sar_search_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_if
//  Description : Handshake/comparator bundle between the SAR search
//                controller and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic             greater;
    logic             less;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic             exact;
    logic [WIDTH-1:0] result;

    // Environment side: issues start/abort and returns the comparator verdict.
    modport master (
        output start, abort, greater, less,
        input  trial, busy, done, exact, result
    );

    // Controller side.
    modport slave (
        input  start, abort, greater, less,
        output trial, busy, done, exact, result
    );
endinterface
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search
//  Description : Successive-approximation search controller; walks trial
//                codes MSB-first against an external comparator verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    sar_search_if.slave   bus
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    C_IDX_MSB   = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_TEST = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_trial;
    logic [IW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_exact;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_kept;
    logic             w_equal;

    // Bit under test; a "greater" verdict (including greater&less) drops it.
    assign w_bit   = C_ONE << r_idx;
    assign w_kept  = bus.greater ? (r_trial & ~w_bit) : r_trial;
    assign w_equal = !bus.greater && !bus.less;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_trial  <= '0;
            r_idx    <= C_IDX_MSB;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_exact  <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_trial <= '0;
                    r_busy  <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        r_trial <= C_TRIAL_MSB;
                        r_idx   <= C_IDX_MSB;
                        r_exact <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_TEST;
                    end
                end
                S_TEST: begin
                    if (bus.abort) begin
                        r_trial <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_equal) begin
                        r_result <= r_trial;
                        r_exact  <= 1'b1;
                        r_done   <= 1'b1;
                        r_trial  <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_idx == '0) begin
                        // Last bit resolved by inequality: converged, not exact.
                        r_result <= w_kept;
                        r_exact  <= 1'b0;
                        r_done   <= 1'b1;
                        r_trial  <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_trial <= w_kept | (w_bit >> 1);
                        r_idx   <= r_idx - IW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trial <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trial  = r_trial;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.exact  = r_exact;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search
//  Description : Scoreboard bench for sar_search with a model comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search;
    localparam int WIDTH = 4;

    typedef struct {
        int res;
        bit ex;
        int n;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] tgt;

    int   n_cmp;
    int   n_bad;
    int   exp_trial[$];
    exp_t exp_done[$];

    sar_search_if #(.WIDTH(WIDTH)) bus ();

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model comparator against the hidden target.
    assign bus.greater = (bus.trial > tgt);
    assign bus.less    = (bus.trial < tgt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a binary search keeps the target's bits above i and probes bit i.
    task automatic push_search(input int t);
        int n;
        int tr;
        exp_t e;
        n  = 0;
        tr = -1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            tr = ((t >> (i + 1)) << (i + 1)) | (1 << i);
            exp_trial.push_back(tr);
            n++;
            if (tr == t) break;
        end
        e.res = t;
        e.ex  = (tr == t);
        e.n   = n;
        exp_done.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_search(input int t);
        tgt = WIDTH'(t);
        push_search(t);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("search");
    endtask

    // Monitor: checks every busy trial, and every done strobe against the queue.
    int cnt;
    bit done_prev;
    initial begin
        cnt       = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt       = 0;
                done_prev = 1'b0;
            end else begin
                if (bus.busy) begin
                    cnt++;
                    if (exp_trial.size() == 0) chk("trial_unexpected", int'(bus.trial), -1);
                    else chk("trial", int'(bus.trial), exp_trial.pop_front());
                end else begin
                    if (bus.trial != '0) chk("idle_trial", int'(bus.trial), 0);
                end
                if (bus.done) begin
                    exp_t e;
                    if (done_prev) chk("done_width", 2, 1);
                    chk("busy_at_done", int'(bus.busy), 0);
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        e = exp_done.pop_front();
                        chk("result", int'(bus.result), e.res);
                        chk("exact", int'(bus.exact), int'(e.ex));
                        chk("latency", cnt, e.n);
                    end
                    cnt = 0;
                end else if (!bus.busy) begin
                    cnt = 0;
                end
                done_prev = bus.done;
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        tgt       = '0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trial", int'(bus.trial), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_exact", int'(bus.exact), 0);
        chk("rst_result", int'(bus.result), 0);
        rst_n = 1'b1;

        do_search(10);
        do_search(0);
        do_search(15);
        for (int t = 0; t < (1 << WIDTH); t++) do_search(t);

        // start held high: ignored mid-search, re-accepted in the done cycle.
        tgt = WIDTH'(5);
        push_search(5);
        push_search(5);
        bus.start = 1'b1;
        wait_done("held1");
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("held_restart_trial", int'(bus.trial), 8);
        wait_done("held2");

        // Abort on the second TEST edge leaves result untouched.
        do_search(10);
        tgt = WIDTH'(3);
        exp_trial.push_back(8);
        exp_trial.push_back(4);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_trial", int'(bus.trial), 0);
        chk("abort_busy", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_result", int'(bus.result), 10);
        chk("abort_exact", int'(bus.exact), 0);

        // Reset in the second TEST cycle clears everything at once.
        tgt = WIDTH'(9);
        exp_trial.push_back(8);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_trial", int'(bus.trial), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_exact", int'(bus.exact), 0);
        chk("mid_rst_result", int'(bus.result), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_search(6);

        // Randomized searches with random idle gaps (gap 0 = back-to-back).
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_search(int'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("trial_queue_left", exp_trial.size(), 0);
        chk("done_queue_left", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
